// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the serial program loader.
package prog_loader_pkg;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: input synchronizer, baud counter and receive FSM.
module uart_rx_byte
    import prog_loader_pkg::*;
#(
    parameter int unsigned ClksPerBit = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o,
    output logic       start_o,
    output logic       busy_o
);

    localparam int unsigned CntW = $clog2(ClksPerBit);
    localparam logic [CntW-1:0] FullCnt = CntW'(ClksPerBit - 1);
    localparam logic [CntW-1:0] HalfCnt = CntW'(ClksPerBit / 2 - 1);

    logic            rx_meta_q, rx_sync_q;
    rx_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        byte_valid_o = 1'b0;
        frame_err_o  = 1'b0;
        start_o      = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (!rx_sync_q) state_d = RX_START;
            end
            RX_START: begin
                if (cnt_q == HalfCnt) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    // A start bit that is gone by mid-bit was a glitch
                    if (!rx_sync_q) begin
                        state_d = RX_DATA;
                        start_o = 1'b1;
                    end else begin
                        state_d = RX_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == FullCnt) begin
                    cnt_d     = '0;
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = RX_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == FullCnt) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    if (rx_sync_q) byte_valid_o = 1'b1;
                    else           frame_err_o  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign byte_o = shift_q;
    assign busy_o = (state_q != RX_IDLE);

endmodule

// File: rtl/prog_loader.sv
// Serial program loader: packs UART bytes into 32-bit words and writes them
// into instruction memory, flagging image progress, completion and errors.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 50000000,
    parameter int unsigned BAUD         = 115200,
    parameter int unsigned MEM_SIZE     = 64,
    parameter int unsigned TIMEOUT_BITS = 32
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        uart_rx,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        loading,
    output logic        done,
    output logic        err
);

    localparam int unsigned ClksPerBit = CLK_HZ / BAUD;
    localparam int unsigned CntW       = $clog2(ClksPerBit);
    localparam int unsigned TmoW       = $clog2(TIMEOUT_BITS + 1);
    localparam logic [CntW-1:0] BitEnd   = CntW'(ClksPerBit - 1);
    localparam logic [TmoW-1:0] TmoLast  = TmoW'(TIMEOUT_BITS - 1);
    localparam logic [31:0]     LastAddr = 32'(MEM_SIZE - WORD_BYTES);

    logic [7:0] rx_byte;
    logic       rx_valid, rx_frame_err, rx_start, rx_busy;

    uart_rx_byte #(
        .ClksPerBit (ClksPerBit)
    ) u_rx (
        .clk_i        (sys_clk),
        .rst_ni       (sys_rst),
        .rx_i         (uart_rx),
        .byte_o       (rx_byte),
        .byte_valid_o (rx_valid),
        .frame_err_o  (rx_frame_err),
        .start_o      (rx_start),
        .busy_o       (rx_busy)
    );

    logic [1:0]      byte_idx_q, byte_idx_d;
    logic [23:0]     buf_q, buf_d;
    logic [31:0]     addr_q, addr_d;
    logic            wr_en_q, wr_en_d;
    logic [31:0]     wr_addr_q, wr_addr_d;
    logic [31:0]     wr_data_q, wr_data_d;
    logic            loading_q, loading_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [CntW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [TmoW-1:0] tmo_bits_q, tmo_bits_d;

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            byte_idx_q <= '0;
            buf_q      <= '0;
            addr_q     <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            loading_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            tmo_cnt_q  <= '0;
            tmo_bits_q <= '0;
        end else begin
            byte_idx_q <= byte_idx_d;
            buf_q      <= buf_d;
            addr_q     <= addr_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            loading_q  <= loading_d;
            done_q     <= done_d;
            err_q      <= err_d;
            tmo_cnt_q  <= tmo_cnt_d;
            tmo_bits_q <= tmo_bits_d;
        end
    end

    always_comb begin
        byte_idx_d = byte_idx_q;
        buf_d      = buf_q;
        addr_d     = addr_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        loading_d  = loading_q;
        done_d     = 1'b0;
        err_d      = err_q;
        tmo_cnt_d  = '0;
        tmo_bits_d = '0;

        // Loading drops the cycle after the final write's done pulse
        if (done_q) loading_d = 1'b0;

        // Idle bit-time counter; any receiver activity restarts it
        if (loading_q && !rx_busy) begin
            tmo_bits_d = tmo_bits_q;
            if (tmo_cnt_q == BitEnd) begin
                if (tmo_bits_q == TmoLast) begin
                    tmo_bits_d = '0;
                    byte_idx_d = '0;
                    addr_d     = '0;
                    loading_d  = 1'b0;
                    err_d      = 1'b1;
                end else begin
                    tmo_bits_d = tmo_bits_q + 1'b1;
                end
            end else begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
        end

        if (rx_start)     err_d = 1'b0;
        if (rx_frame_err) err_d = 1'b1;

        if (rx_valid) begin
            loading_d  = 1'b1;
            err_d      = 1'b0;
            byte_idx_d = byte_idx_q + 2'd1;
            unique case (byte_idx_q)
                2'd0: buf_d[7:0]   = rx_byte;
                2'd1: buf_d[15:8]  = rx_byte;
                2'd2: buf_d[23:16] = rx_byte;
                2'd3: begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = {rx_byte, buf_q};
                    if (addr_q == LastAddr) begin
                        done_d = 1'b1;
                        addr_d = '0;
                    end else begin
                        addr_d = addr_q + 32'd4;
                    end
                end
                default: ;
            endcase
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign loading = loading_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader against a byte-level image model.
module tb_prog_loader;

    localparam int unsigned CPB = 16;
    localparam int unsigned MEM = 16;
    localparam int unsigned TMO = 32;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b0;
    logic        uart_rx = 1'b1;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        loading;
    logic        done;
    logic        err;

    prog_loader #(
        .CLK_HZ       (1600),
        .BAUD         (100),
        .MEM_SIZE     (MEM),
        .TIMEOUT_BITS (TMO)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .uart_rx (uart_rx),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .loading (loading),
        .done    (done),
        .err     (err)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;
    int stray_done = 0;

    logic [64:0] obs_q[$];
    logic [64:0] exp_q[$];

    always @(negedge sys_clk) begin
        if (wr_en) obs_q.push_back({done, wr_addr, wr_data});
        if (done && !wr_en) stray_done++;
    end

    // Reference model: image state in plain integers and byte arrays
    logic [7:0] m_bytes[4];
    int         m_idx;
    int         m_addr;
    bit         m_loading;
    bit         m_err;

    task automatic chk(input string tag, input logic [64:0] o, input logic [64:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic model_reset();
        m_idx = 0;
        m_addr = 0;
        m_loading = 0;
        m_err = 0;
    endtask

    task automatic check_writes(input string tag);
        logic [64:0] o, e;
        chk({tag, "_count"}, 65'(obs_q.size()), 65'(exp_q.size()));
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            chk({tag, "_word"}, o, e);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic check_flags(input string tag);
        chk({tag, "_loading"}, 65'(loading), 65'(m_loading));
        chk({tag, "_err"}, 65'(err), 65'(m_err));
    endtask

    task automatic model_byte(input logic [7:0] b, input bit stop_ok);
        bit fin;
        if (!stop_ok) begin
            m_err = 1;
            return;
        end
        m_err = 0;
        m_loading = 1;
        m_bytes[m_idx] = b;
        m_idx++;
        if (m_idx == 4) begin
            fin = (m_addr == MEM - 4);
            exp_q.push_back({fin, 32'(m_addr), m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]});
            m_idx = 0;
            m_addr = fin ? 0 : m_addr + 4;
            if (fin) m_loading = 0;
        end
    endtask

    // Start bit, 8 data bits LSB first, stop bit, then one idle bit
    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        uart_rx = 1'b0;
        cyc(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            cyc(CPB);
        end
        uart_rx = stop_ok;
        cyc(CPB);
        uart_rx = 1'b1;
        cyc(CPB);
        model_byte(b, stop_ok);
        check_writes("byte");
        check_flags("byte");
    endtask

    task automatic idle_bits(input int n);
        cyc(n * CPB);
        if (n > TMO && m_loading) begin
            m_idx = 0;
            m_addr = 0;
            m_loading = 0;
            m_err = 1;
        end
        check_writes("idle");
        check_flags("idle");
    endtask

    task automatic do_reset();
        sys_rst = 1'b0;
        uart_rx = 1'b1;
        cyc(3);
        model_reset();
        obs_q.delete();
        exp_q.delete();
        sys_rst = 1'b1;
        cyc(2);
    endtask

    initial begin
        logic [7:0] rb;
        bit         rok;

        // Reset values
        do_reset();
        chk("rst_wr_en", 65'(wr_en), 65'd0);
        chk("rst_wr_addr", 65'(wr_addr), 65'd0);
        chk("rst_wr_data", 65'(wr_data), 65'd0);
        chk("rst_loading", 65'(loading), 65'd0);
        chk("rst_done", 65'(done), 65'd0);
        chk("rst_err", 65'(err), 65'd0);

        // Single word: addi a0,zero,1 encoding
        send_byte(8'h13, 1'b1);
        send_byte(8'h05, 1'b1);
        send_byte(8'h10, 1'b1);
        exp_q.push_back({1'b0, 32'h0, 32'h0010_0513});
        model_byte(8'h00, 1'b1);
        exp_q.pop_back();
        exp_q.push_back({1'b0, 32'h0, 32'h0010_0513});
        m_idx = 3;
        m_addr = 0;
        m_loading = 1;
        exp_q.delete();
        send_byte(8'h00, 1'b1);

        // Full image of 16 bytes, then 4 more bytes restart at address 0
        do_reset();
        for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b1);
        chk("img_loading_after", 65'(loading), 65'd0);
        chk("img_addr12_data", 65'(wr_data), 65'h0F0E_0D0C);
        for (int i = 0; i < 4; i++) send_byte(8'(8'hA0 + i), 1'b1);
        chk("img_wrap_addr", 65'(wr_addr), 65'd0);

        // Framing error keeps the lane, next bytes fill it
        do_reset();
        send_byte(8'hAA, 1'b0);
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b1);
        chk("ferr_word", 65'(wr_data), 65'h0403_0201);

        // Quarter-bit glitch while idle must not produce a byte
        uart_rx = 1'b0;
        cyc(CPB / 4);
        uart_rx = 1'b1;
        idle_bits(2);

        // Timeout mid-image
        do_reset();
        send_byte(8'h55, 1'b1);
        send_byte(8'h66, 1'b1);
        idle_bits(TMO + 1);
        for (int i = 0; i < 4; i++) send_byte(8'(8'hC0 + i), 1'b1);
        chk("tmo_addr", 65'(wr_addr), 65'd0);

        // Reset during the 3rd byte of a word
        do_reset();
        for (int i = 0; i < 4; i++) send_byte(8'(8'hA1 + 8'h11 * i), 1'b1);
        send_byte(8'h77, 1'b1);
        send_byte(8'h88, 1'b1);
        uart_rx = 1'b0;
        cyc(CPB);
        uart_rx = 1'b1;
        cyc(3 * CPB);
        sys_rst = 1'b0;
        #1;
        chk("mid_rst_wr_en", 65'(wr_en), 65'd0);
        chk("mid_rst_wr_addr", 65'(wr_addr), 65'd0);
        chk("mid_rst_wr_data", 65'(wr_data), 65'd0);
        chk("mid_rst_loading", 65'(loading), 65'd0);
        chk("mid_rst_done", 65'(done), 65'd0);
        chk("mid_rst_err", 65'(err), 65'd0);
        uart_rx = 1'b1;
        cyc(3);
        model_reset();
        check_writes("mid_rst");
        sys_rst = 1'b1;
        cyc(2);
        for (int i = 0; i < 4; i++) send_byte(8'(8'h31 + i), 1'b1);

        // Random images with occasional framing errors and short gaps
        do_reset();
        for (int i = 0; i < 40; i++) begin
            rb  = 8'($urandom_range(0, 255));
            rok = ($urandom_range(0, 7) != 0);
            send_byte(rb, rok);
            idle_bits(int'($urandom_range(0, 2)));
        end

        chk("stray_done", 65'(stray_done), 65'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
